// File: rtl/opb_s2p_pkg.sv
// opb_s2p_pkg
//   Shared constants and types for the fabric-to-PowerPC readback register
//   bank and its OPB acknowledge FSM.
//   - OFF_*        : byte offsets of the register map inside the slave window
//   - WORD_*       : the same offsets as 32-bit word indices
//   - CTRL_*_BIT   : bit positions inside the CTRL word (LSB = OPB_DBus[31])
//   - ack_state_t  : states of the three-state OPB handshake
package opb_s2p_pkg;

  // Window is 256 bytes, so eight offset bits cover it.
  localparam int OFF_W = 8;

  localparam logic [OFF_W-1:0] OFF_CTRL    = 8'h00;
  localparam logic [OFF_W-1:0] OFF_CAPCNT  = 8'h04;
  localparam logic [OFF_W-1:0] OFF_SHADOW0 = 8'h08;

  localparam logic [OFF_W-3:0] WORD_CTRL    = OFF_CTRL[OFF_W-1:2];
  localparam logic [OFF_W-3:0] WORD_CAPCNT  = OFF_CAPCNT[OFF_W-1:2];
  localparam logic [OFF_W-3:0] WORD_SHADOW0 = OFF_SHADOW0[OFF_W-1:2];

  localparam int CTRL_FREEZE_BIT = 0;
  localparam int CTRL_SWCAP_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    GUARD = 2'd2
  } ack_state_t;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// opb_slave_ack_fsm
//   Address-window decode and acknowledge handshake for a simple OPB slave.
//   Ports:
//     clk, rst_n   : OPB clock, synchronous active-low reset
//     abus         : OPB address (big-endian bit order, numeric value used)
//     rnw, select  : OPB read-not-write and transfer request
//     access       : one-cycle pulse on the edge that accepts a transfer
//     offset       : byte offset from the base address, valid with access
//     acc_rnw      : direction of the accepted transfer, valid with access
//     xfer_ack     : registered acknowledge, high for exactly one cycle
//     state        : current handshake state (debug visibility)
//
//   Handshake: the master raises select with a stable address and keeps it
//   until it sees xfer_ack. A select that hits the window in IDLE is accepted
//   on that edge (access = 1); xfer_ack is high for the following cycle only.
//   GUARD then swallows one more cycle so a master that drops select one
//   cycle late is not acknowledged twice. Out-of-window selects are ignored.
module opb_slave_ack_fsm
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_4400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_44FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic                  rnw,
  input  logic                  select,
  output logic                  access,
  output logic [OFF_W-1:0]      offset,
  output logic                  acc_rnw,
  output logic                  xfer_ack,
  output ack_state_t            state
);

  localparam logic [C_OPB_AWIDTH-1:0] BASE = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [C_OPB_AWIDTH-1:0] HIGH = C_HIGHADDR[C_OPB_AWIDTH-1:0];

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] rel;
  logic                    hit;
  logic                    unused_rel;

  // Assigning the ascending-range bus to a descending vector keeps the
  // numeric value (abus[C_OPB_AWIDTH-1] is the LSB).
  assign addr    = abus;
  assign hit     = (addr >= BASE) && (addr <= HIGH);
  assign rel     = addr - BASE;
  assign offset  = rel[OFF_W-1:0];
  assign acc_rnw = rnw;

  // Combinational so the register bank can act on the same accepting edge.
  assign access = (state == IDLE) && select && hit;

  assign unused_rel = &{1'b0, rel[C_OPB_AWIDTH-1:OFF_W]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      xfer_ack <= 1'b0;
    end else begin
      xfer_ack <= access;
      case (state)
        IDLE:    if (access) state <= ACK;
        ACK:     state <= GUARD;
        GUARD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/opb_simulink2ppc_regbank.sv
// opb_simulink2ppc_regbank
//   OPB slave exposing C_NUM_REGS 32-bit words snapshotted from fabric logic.
//   Ports:
//     OPB_Clk, OPB_Rst_n         : clock, synchronous active-low reset
//     OPB_ABus/BE/DBus/RNW       : OPB address, byte enables, write data, dir
//     OPB_select, OPB_seqAddr    : transfer request; seqAddr is ignored
//     Sl_DBus, Sl_xferAck        : registered read data and one-cycle ack
//     Sl_errAck/retry/toutSup    : tied low
//     user_data_in               : fabric words, word k = [32k+31:32k]
//     user_capture               : one-cycle capture strobe from fabric
//     user_frozen                : CTRL.freeze
//     fsm_state                  : handshake state (debug visibility)
//   Map: 0x00 CTRL {sw_capture(w1, reads 0), freeze}, 0x04 CAPCNT,
//        0x08+4k SHADOW[k]; everything else reads 0 and ignores writes.
module opb_simulink2ppc_regbank
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_4400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_44FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [32*C_NUM_REGS-1:0] user_data_in,
  input  logic                    user_capture,
  output logic                    user_frozen,
  output logic [1:0]              fsm_state
);

  logic             access;
  logic             acc_rnw;
  logic [OFF_W-1:0] offset;
  ack_state_t       ack_state;

  logic [31:0] wdata;
  logic [5:0]  word;
  logic        ctrl_wr;
  logic        sw_cap;
  logic        freeze;
  logic        freeze_nxt;
  logic        capture;
  logic [31:0] capcnt;
  logic [31:0] shadow [C_NUM_REGS];
  logic [31:0] rd_data;
  logic [31:0] dbus_q;
  logic        unused_ok;

  opb_slave_ack_fsm #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH)
  ) u_ack (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .abus     (OPB_ABus),
    .rnw      (OPB_RNW),
    .select   (OPB_select),
    .access   (access),
    .offset   (offset),
    .acc_rnw  (acc_rnw),
    .xfer_ack (Sl_xferAck),
    .state    (ack_state)
  );

  // Numeric view of the write bus: wdata[0] is OPB_DBus[31].
  assign wdata = OPB_DBus;
  assign word  = offset[OFF_W-1:2];

  // CTRL writes are honoured only with the least significant byte lane.
  assign ctrl_wr    = access && !acc_rnw && (word == WORD_CTRL) && OPB_BE[3];
  assign freeze_nxt = ctrl_wr ? wdata[CTRL_FREEZE_BIT] : freeze;
  assign sw_cap     = ctrl_wr && wdata[CTRL_SWCAP_BIT];
  // Gate on the post-write freeze value so "unfreeze + sw_capture" in one
  // write captures immediately; fabric and software strobes merge into one.
  assign capture    = (user_capture || sw_cap) && !freeze_nxt;

  // Read mux sees pre-edge register values, so a capture on the accepting
  // edge is only visible to the next read.
  always_comb begin
    rd_data = 32'h0;
    if (word == WORD_CTRL) begin
      rd_data[CTRL_FREEZE_BIT] = freeze;
    end else if (word == WORD_CAPCNT) begin
      rd_data = capcnt;
    end else begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (word == WORD_SHADOW0 + 6'(k)) rd_data = shadow[k];
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      freeze <= 1'b0;
      capcnt <= 32'h0;
      dbus_q <= 32'h0;
      for (int k = 0; k < C_NUM_REGS; k++) shadow[k] <= 32'h0;
    end else begin
      freeze <= freeze_nxt;
      if (capture) begin
        capcnt <= capcnt + 32'd1;
        for (int k = 0; k < C_NUM_REGS; k++) shadow[k] <= user_data_in[32*k +: 32];
      end
      // Data is driven only for the ack cycle; zero otherwise.
      dbus_q <= (access && acc_rnw) ? rd_data : 32'h0;
    end
  end

  assign Sl_DBus     = dbus_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_frozen = freeze;
  assign fsm_state   = ack_state;

  assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], wdata[31:2], offset[1:0]};

endmodule
